// File: rtl/msg_buf_pkg.sv
// Shared definitions for the message buffer reader.
//   BYTE_W  : width of one stored byte
//   state_t : readback FSM states (IDLE, READ, FIN)
package msg_buf_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/msg_buf_mem.sv
// Byte store for the message buffer: DEPTH x BYTE_W register array with one
// synchronous write port and one combinational read port. Contents are not
// reset.
//   clk      : clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write byte
//   raddr_i  : read address
//   rdata_o  : byte at raddr_i (combinational)
module msg_buf_mem
  import msg_buf_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [BYTE_W-1:0]        wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [BYTE_W-1:0]        rdata_o
);

  logic [BYTE_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/msg_buf_reader.sv
// Message buffer reader: collects bytes while idle, then on a disp pulse
// streams them out over a valid/ready interface, pulses done and empties
// the buffer. Writes that cannot be stored set a sticky overflow flag.
//   clk      : clock
//   rst_b    : asynchronous active-low reset
//   wr, dat  : byte write strobe and data
//   disp     : readback trigger pulse
//   out_vld, out_rdy, out_dat, out_last : readback stream
//   busy     : readback in progress (READ or FIN)
//   done     : one-cycle pulse when a readback completes
//   ovf      : sticky, a write was dropped
// Build option: define MSG_BUF_NUL_TERM_EN to append an 8'h00 terminator
// beat to every readback (out_last then marks only that beat).
//
// state | meaning
// IDLE  | accepting writes, waiting for disp
// READ  | streaming stored bytes, out_vld=1
// FIN   | done pulse, buffer pointers/count cleared
module msg_buf_reader
  import msg_buf_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              wr,
  input  logic [BYTE_W-1:0] dat,
  input  logic              disp,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [BYTE_W-1:0] out_dat,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            wr_acc;
  logic            xfer;
  logic            data_last;
  logic [BYTE_W-1:0] rd_byte;
`ifdef MSG_BUF_NUL_TERM_EN
  // Set once the stored bytes are exhausted; the current beat is the NUL.
  logic            nul_q, nul_d;
`endif

  msg_buf_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (dat),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_byte)
  );

  assign wr_acc    = wr && (state_q == IDLE) && (count_q < CW'(DEPTH));
  assign out_vld   = (state_q == READ);
  assign xfer      = out_vld && out_rdy;
  assign data_last = ({1'b0, rd_ptr_q} == (count_q - CW'(1)));
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign ovf       = ovf_q;

`ifdef MSG_BUF_NUL_TERM_EN
  assign out_dat  = (out_vld && !nul_q) ? rd_byte : '0;
  assign out_last = out_vld && nul_q;
`else
  assign out_dat  = out_vld ? rd_byte : '0;
  assign out_last = out_vld && data_last;
`endif

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (wr & ~wr_acc);
`ifdef MSG_BUF_NUL_TERM_EN
    nul_d    = nul_q;
`endif

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      count_d  = count_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        // count_d already includes a write accepted in the same cycle,
        // so that byte is part of this readback.
        if (disp) begin
          rd_ptr_d = '0;
`ifdef MSG_BUF_NUL_TERM_EN
          state_d  = READ;
          nul_d    = (count_d == '0);
`else
          state_d  = (count_d != '0) ? READ : FIN;
`endif
        end
      end
      READ: begin
        if (xfer) begin
`ifdef MSG_BUF_NUL_TERM_EN
          if (nul_q) begin
            state_d = FIN;
          end else if (data_last) begin
            nul_d = 1'b1;
          end else begin
            rd_ptr_d = rd_ptr_q + PW'(1);
          end
`else
          if (data_last) begin
            state_d = FIN;
          end else begin
            rd_ptr_d = rd_ptr_q + PW'(1);
          end
`endif
        end
      end
      FIN: begin
        count_d  = '0;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
`ifdef MSG_BUF_NUL_TERM_EN
        nul_d    = 1'b0;
`endif
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
`ifdef MSG_BUF_NUL_TERM_EN
      nul_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
`ifdef MSG_BUF_NUL_TERM_EN
      nul_q    <= nul_d;
`endif
    end
  end

endmodule
